fetch_redirect_ctrl: RTL and testbench

Central scheduler for the fetch PC register. Each cycle it decides which source writes the next PC: backend redirect, IF3 redirect, a pending delay-slot target, an NLP prediction for slot 0 or slot 1, or the sequential PC. It holds redirects that arrive while fetch is paused, sequences delay-slot-first fetches, and produces the frontend flush and epoch tag.

---
 rtl/fetch_redirect_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC scheduler: arbitrates backend/IF3 redirects, NLP predictions and the
// sequential PC. It holds redirects while fetch is paused and sequences delay-slot-first fetches.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter int unsigned EPOCH_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pause,
  input  logic [31:0]        seq_pc,
  input  logic               be_valid,
  input  logic [31:0]        be_pc,
  output logic               be_ready,
  input  logic               if3_valid,
  input  logic [31:0]        if3_pc,
  input  logic               if3_need_ds,
  input  logic [31:0]        if3_ds_pc,
  input  logic               nlp0_taken,
  input  logic [31:0]        nlp0_target,
  input  logic               nlp1_taken,
  input  logic [31:0]        nlp1_target,
  output logic               pc_we,
  output logic [31:0]        next_pc,
  output logic               only_get_ds,
  output logic               flush_fe,
  output logic [EPOCH_W-1:0] epoch,
  output logic               busy
);

  // state      | meaning
  // ST_RUN     | normal arbitration between all sources
  // ST_HOLD    | redirect latched in the pending entry, waiting for pause to drop
  // ST_DS_WAIT | delay slot issued, saved target goes out next
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DS_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] pend_ds_pc_q, pend_ds_pc_d;
  logic        pend_need_ds_q, pend_need_ds_d;
  logic        pend_is_be_q, pend_is_be_d;
  logic [31:0] saved_pc_q, saved_pc_d;

  logic               pc_we_q, pc_we_d;
  logic [31:0]        next_pc_q, next_pc_d;
  logic               only_get_ds_q, only_get_ds_d;
  logic               flush_fe_q, flush_fe_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               be_ready_q, be_ready_d;
  logic               busy_q, busy_d;

  logic        be_acc;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_ds_pc;
  logic        rd_need_ds;
  logic        rd_is_be;

  assign be_acc = be_valid && be_ready_q;

  // Redirect winner this cycle. IF3 only competes in RUN; in HOLD an accepted
  // backend request can only displace a pending IF3 entry since be_ready is low otherwise.
  always_comb begin
    rd_valid   = 1'b0;
    rd_pc      = pend_pc_q;
    rd_ds_pc   = pend_ds_pc_q;
    rd_need_ds = pend_need_ds_q;
    rd_is_be   = pend_is_be_q;
    if (be_acc) begin
      rd_valid   = 1'b1;
      rd_pc      = be_pc;
      rd_ds_pc   = be_pc;
      rd_need_ds = 1'b0;
      rd_is_be   = 1'b1;
    end else if (state_q == ST_HOLD) begin
      rd_valid = 1'b1;
    end else if (state_q == ST_RUN && if3_valid) begin
      rd_valid   = 1'b1;
      rd_pc      = if3_pc;
      rd_ds_pc   = if3_ds_pc;
      rd_need_ds = if3_need_ds;
      rd_is_be   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      pend_pc_q      <= '0;
      pend_ds_pc_q   <= '0;
      pend_need_ds_q <= 1'b0;
      pend_is_be_q   <= 1'b0;
      saved_pc_q     <= '0;
      pc_we_q        <= 1'b0;
      next_pc_q      <= RESET_PC;
      only_get_ds_q  <= 1'b0;
      flush_fe_q     <= 1'b0;
      epoch_q        <= '0;
      be_ready_q     <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_pc_q      <= pend_pc_d;
      pend_ds_pc_q   <= pend_ds_pc_d;
      pend_need_ds_q <= pend_need_ds_d;
      pend_is_be_q   <= pend_is_be_d;
      saved_pc_q     <= saved_pc_d;
      pc_we_q        <= pc_we_d;
      next_pc_q      <= next_pc_d;
      only_get_ds_q  <= only_get_ds_d;
      flush_fe_q     <= flush_fe_d;
      epoch_q        <= epoch_d;
      be_ready_q     <= be_ready_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pend_pc_d      = pend_pc_q;
    pend_ds_pc_d   = pend_ds_pc_q;
    pend_need_ds_d = pend_need_ds_q;
    pend_is_be_d   = pend_is_be_q;
    saved_pc_d     = saved_pc_q;
    if (rd_valid) begin
      if (pause) begin
        state_d        = ST_HOLD;
        pend_pc_d      = rd_pc;
        pend_ds_pc_d   = rd_ds_pc;
        pend_need_ds_d = rd_need_ds;
        pend_is_be_d   = rd_is_be;
      end else if (rd_need_ds) begin
        state_d    = ST_DS_WAIT;
        saved_pc_d = rd_pc;
      end else begin
        state_d = ST_RUN;
      end
    end else if (!pause) begin
      if (state_q != ST_RUN) begin
        state_d = ST_RUN;
      end else if (!nlp0_taken && nlp1_taken) begin
        state_d    = ST_DS_WAIT;
        saved_pc_d = nlp1_target;
      end
    end
  end

  always_comb begin
    pc_we_d       = !pause;
    next_pc_d     = next_pc_q;
    only_get_ds_d = only_get_ds_q;
    flush_fe_d    = 1'b0;
    epoch_d       = epoch_q;
    if (!pause) begin
      if (rd_valid) begin
        next_pc_d     = rd_need_ds ? rd_ds_pc : rd_pc;
        only_get_ds_d = rd_need_ds;
        flush_fe_d    = 1'b1;
        epoch_d       = epoch_q + EPOCH_W'(1);
      end else if (state_q == ST_DS_WAIT) begin
        next_pc_d     = saved_pc_q;
        only_get_ds_d = 1'b0;
      end else if (nlp0_taken) begin
        next_pc_d     = nlp0_target;
        only_get_ds_d = 1'b0;
      end else begin
        // nlp1 fetches its own delay slot at seq_pc before the target
        next_pc_d     = seq_pc;
        only_get_ds_d = nlp1_taken;
      end
    end
    be_ready_d = !(state_d == ST_HOLD && pend_is_be_d);
    busy_d     = (state_d != ST_RUN);
  end

  assign pc_we       = pc_we_q;
  assign next_pc     = next_pc_q;
  assign only_get_ds = only_get_ds_q;
  assign flush_fe    = flush_fe_q;
  assign epoch       = epoch_q;
  assign be_ready    = be_ready_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed vector table, reset corner case, and
// randomized traffic compared against a pending-entry/delay-slot reference model.
module tb_fetch_redirect_ctrl;

  localparam logic [31:0] RST_PC = 32'hbfc00000;
  localparam int EW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pause;
  logic [31:0]   seq_pc;
  logic          be_valid;
  logic [31:0]   be_pc;
  logic          be_ready;
  logic          if3_valid;
  logic [31:0]   if3_pc;
  logic          if3_need_ds;
  logic [31:0]   if3_ds_pc;
  logic          nlp0_taken;
  logic [31:0]   nlp0_target;
  logic          nlp1_taken;
  logic [31:0]   nlp1_target;
  logic          pc_we;
  logic [31:0]   next_pc;
  logic          only_get_ds;
  logic          flush_fe;
  logic [EW-1:0] epoch;
  logic          busy;

  int total = 0;
  int bad   = 0;

  fetch_redirect_ctrl #(.RESET_PC(RST_PC), .EPOCH_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .pause(pause), .seq_pc(seq_pc),
    .be_valid(be_valid), .be_pc(be_pc), .be_ready(be_ready),
    .if3_valid(if3_valid), .if3_pc(if3_pc), .if3_need_ds(if3_need_ds), .if3_ds_pc(if3_ds_pc),
    .nlp0_taken(nlp0_taken), .nlp0_target(nlp0_target),
    .nlp1_taken(nlp1_taken), .nlp1_target(nlp1_target),
    .pc_we(pc_we), .next_pc(next_pc), .only_get_ds(only_get_ds),
    .flush_fe(flush_fe), .epoch(epoch), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          p;
    logic [31:0] seq;
    bit          be_v;
    logic [31:0] be_pc;
    bit          if3_v;
    logic [31:0] if3_pc;
    bit          need_ds;
    logic [31:0] ds_pc;
    bit          n0;
    logic [31:0] n0_t;
    bit          n1;
    logic [31:0] n1_t;
    bit          e_we;
    logic [31:0] e_pc;
    bit          e_ogd;
    bit          e_fl;
    int          e_ep;
    bit          e_rdy;
    bit          e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit p, input logic [31:0] seq);
    vec_t v;
    v.p = p; v.seq = seq;
    v.be_v = 0; v.be_pc = '0; v.if3_v = 0; v.if3_pc = '0; v.need_ds = 0; v.ds_pc = '0;
    v.n0 = 0; v.n0_t = '0; v.n1 = 0; v.n1_t = '0;
    v.e_we = 0; v.e_pc = '0; v.e_ogd = 0; v.e_fl = 0; v.e_ep = 0; v.e_rdy = 1; v.e_busy = 0;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input bit we, input logic [31:0] pc, input bit ogd,
                              input bit fl, input int ep, input bit rdy, input bit bsy);
    vec_t v = vi;
    v.e_we = we; v.e_pc = pc; v.e_ogd = ogd; v.e_fl = fl; v.e_ep = ep; v.e_rdy = rdy; v.e_busy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pause = v.p; seq_pc = v.seq;
    be_valid = v.be_v; be_pc = v.be_pc;
    if3_valid = v.if3_v; if3_pc = v.if3_pc; if3_need_ds = v.need_ds; if3_ds_pc = v.ds_pc;
    nlp0_taken = v.n0; nlp0_target = v.n0_t; nlp1_taken = v.n1; nlp1_target = v.n1_t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc_we"}, 32'(pc_we), 32'd0);
    chk({tag, "_next_pc"}, next_pc, RST_PC);
    chk({tag, "_ogd"}, 32'(only_get_ds), 32'd0);
    chk({tag, "_flush"}, 32'(flush_fe), 32'd0);
    chk({tag, "_epoch"}, 32'(epoch), 32'd0);
    chk({tag, "_be_ready"}, 32'(be_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Reference model: an optional held redirect and an optional delay-slot follow-up target.
  bit          m_pend_valid, m_pend_be, m_pend_need_ds;
  logic [31:0] m_pend_pc, m_pend_ds_pc;
  bit          m_ds_valid;
  logic [31:0] m_ds_target;
  int          m_epoch;
  bit          m_we, m_ogd, m_fl;
  logic [31:0] m_pc;

  function automatic void m_reset();
    m_pend_valid = 0; m_pend_be = 0; m_pend_need_ds = 0; m_pend_pc = '0; m_pend_ds_pc = '0;
    m_ds_valid = 0; m_ds_target = '0; m_epoch = 0;
    m_we = 0; m_ogd = 0; m_fl = 0; m_pc = RST_PC;
  endfunction

  function automatic void m_step();
    bit          ready = !(m_pend_valid && m_pend_be);
    bit          have = 0, r_be = 0, r_ds = 0;
    logic [31:0] r_pc = '0, r_dspc = '0;
    m_we = 0; m_fl = 0;
    if (be_valid && ready) begin
      have = 1; r_be = 1; r_pc = be_pc;
    end else if (m_pend_valid) begin
      have = 1; r_be = m_pend_be; r_pc = m_pend_pc; r_ds = m_pend_need_ds; r_dspc = m_pend_ds_pc;
    end else if (!m_ds_valid && if3_valid) begin
      have = 1; r_pc = if3_pc; r_ds = if3_need_ds; r_dspc = if3_ds_pc;
    end
    if (have) begin
      m_ds_valid = 0;
      if (pause) begin
        m_pend_valid = 1; m_pend_be = r_be; m_pend_pc = r_pc;
        m_pend_need_ds = r_ds; m_pend_ds_pc = r_dspc;
      end else begin
        m_pend_valid = 0;
        m_we = 1; m_fl = 1; m_epoch = (m_epoch + 1) % (1 << EW);
        m_pc = r_ds ? r_dspc : r_pc; m_ogd = r_ds;
        m_ds_valid = r_ds; m_ds_target = r_pc;
      end
    end else if (!pause) begin
      m_we = 1;
      if (m_ds_valid) begin
        m_pc = m_ds_target; m_ogd = 0; m_ds_valid = 0;
      end else if (nlp0_taken) begin
        m_pc = nlp0_target; m_ogd = 0;
      end else if (nlp1_taken) begin
        m_pc = seq_pc; m_ogd = 1; m_ds_valid = 1; m_ds_target = nlp1_target;
      end else begin
        m_pc = seq_pc; m_ogd = 0;
      end
    end
  endfunction

  initial begin
    vec_t v;
    rst_n = 1'b0;
    drive(mk(1, 32'h0));
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");

    // Directed sequences
    v = mk(0, 32'hbfc00008);
    tbl.push_back(ex(v, 1, 32'hbfc00008, 0, 0, 0, 1, 0));
    v = mk(0, 32'h80000010); v.be_v = 1; v.be_pc = 32'h80001000; v.if3_v = 1; v.if3_pc = 32'h80002000;
    tbl.push_back(ex(v, 1, 32'h80001000, 0, 1, 1, 1, 0));
    v = mk(0, 32'h80001004);
    tbl.push_back(ex(v, 1, 32'h80001004, 0, 0, 1, 1, 0));
    v = mk(1, 32'h80001008); v.if3_v = 1; v.if3_pc = 32'h80003000;
    tbl.push_back(ex(v, 0, 32'h0, 0, 0, 1, 1, 1));
    v = mk(1, 32'h80001008); v.be_v = 1; v.be_pc = 32'h80004000;
    tbl.push_back(ex(v, 0, 32'h0, 0, 0, 1, 0, 1));
    v = mk(1, 32'h80001008);
    tbl.push_back(ex(v, 0, 32'h0, 0, 0, 1, 0, 1));
    v = mk(0, 32'h80009000);
    tbl.push_back(ex(v, 1, 32'h80004000, 0, 1, 2, 1, 0));
    v = mk(0, 32'h80004004);
    tbl.push_back(ex(v, 1, 32'h80004004, 0, 0, 2, 1, 0));
    v = mk(0, 32'h80000108); v.n1 = 1; v.n1_t = 32'h80005000;
    tbl.push_back(ex(v, 1, 32'h80000108, 1, 0, 2, 1, 1));
    v = mk(0, 32'h8000010c); v.n0 = 1; v.n0_t = 32'h80007777;
    tbl.push_back(ex(v, 1, 32'h80005000, 0, 0, 2, 1, 0));
    v = mk(0, 32'h80005004); v.if3_v = 1; v.if3_pc = 32'h80006000; v.need_ds = 1; v.ds_pc = 32'h8000010c;
    tbl.push_back(ex(v, 1, 32'h8000010c, 1, 1, 3, 1, 1));
    v = mk(1, 32'h80000110); v.if3_v = 1; v.if3_pc = 32'h80007000;
    tbl.push_back(ex(v, 0, 32'h0, 0, 0, 3, 1, 1));
    v = mk(1, 32'h80000110);
    tbl.push_back(ex(v, 0, 32'h0, 0, 0, 3, 1, 1));
    v = mk(0, 32'h80000110);
    tbl.push_back(ex(v, 1, 32'h80006000, 0, 0, 3, 1, 0));
    for (int i = 0; i < 8; i++) begin
      v = mk(0, 32'h80008000); v.be_v = 1; v.be_pc = 32'h81000000 + 32'(i * 16);
      tbl.push_back(ex(v, 1, v.be_pc, 0, 1, (4 + i) % 8, 1, 0));
    end
    v = mk(0, 32'h80000300); v.n1 = 1; v.n1_t = 32'h80005500;
    tbl.push_back(ex(v, 1, 32'h80000300, 1, 0, 3, 1, 1));

    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      step();
      chk($sformatf("vec%0d_pc_we", i), 32'(pc_we), 32'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("vec%0d_next_pc", i), next_pc, tbl[i].e_pc);
        chk($sformatf("vec%0d_ogd", i), 32'(only_get_ds), 32'(tbl[i].e_ogd));
      end
      chk($sformatf("vec%0d_flush", i), 32'(flush_fe), 32'(tbl[i].e_fl));
      chk($sformatf("vec%0d_epoch", i), 32'(epoch), 32'(tbl[i].e_ep));
      chk($sformatf("vec%0d_be_ready", i), 32'(be_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
    end

    // Reset while a delay-slot follow-up is outstanding must forget it
    rst_n = 1'b0;
    #1;
    chk_reset("dsrst");
    step();
    rst_n = 1'b1;
    drive(mk(0, 32'h80000200));
    step();
    chk("dsrst_pc_we", 32'(pc_we), 32'd1);
    chk("dsrst_next_pc", next_pc, 32'h80000200);
    chk("dsrst_ogd", 32'(only_get_ds), 32'd0);
    chk("dsrst_busy", 32'(busy), 32'd0);

    // Randomized traffic against the reference model
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 250) begin
        rst_n = 1'b0;
        #1;
        chk_reset("rnd_reset");
        m_reset();
        step();
        rst_n = 1'b1;
      end
      pause       = ($urandom_range(0, 9) < 3);
      seq_pc      = $urandom;
      be_valid    = ($urandom_range(0, 9) == 0);
      be_pc       = $urandom;
      if3_valid   = ($urandom_range(0, 9) < 2);
      if3_pc      = $urandom;
      if3_need_ds = $urandom_range(0, 1) == 1;
      if3_ds_pc   = $urandom;
      nlp0_taken  = ($urandom_range(0, 9) < 2);
      nlp0_target = $urandom;
      nlp1_taken  = ($urandom_range(0, 9) < 2);
      nlp1_target = $urandom;
      @(posedge clk);
      m_step();
      #1;
      chk("rnd_pc_we", 32'(pc_we), 32'(m_we));
      if (m_we) begin
        chk("rnd_next_pc", next_pc, m_pc);
        chk("rnd_ogd", 32'(only_get_ds), 32'(m_ogd));
      end
      chk("rnd_flush", 32'(flush_fe), 32'(m_fl));
      chk("rnd_epoch", 32'(epoch), 32'(m_epoch));
      chk("rnd_be_ready", 32'(be_ready), 32'(!(m_pend_valid && m_pend_be)));
      chk("rnd_busy", 32'(busy), 32'(m_pend_valid || m_ds_valid));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
